reg_writeback_arbiter: RTL and testbench
========================================

// Module: reg_writeback_arbiter
// PURPOSE
//  Write-side front end of the 32x32 register file: merges single-cycle ALU results and
//  buffered load (LSU) results into the file's single write port (writeReg/writeData/regWrite).
//  Holds a pending-load scoreboard so decode can stall on RAW hazards against outstanding loads.
//  Sits between the EX/MEM result paths and the register file.
// PARAMETERS
//  DATA_W      32  width of result data / writeData
//  ADDR_W      5   register index width (2**ADDR_W registers)
//  FIFO_DEPTH  2   LSU result buffer entries (power of 2, >=2)
// PORTS
//  clk         in   1       rising-edge clock
//  rst_n       in   1       asynchronous reset, active-low
//  alu_valid   in   1       ALU result present this cycle (always accepted, no ready)
//  alu_reg     in   ADDR_W  ALU destination register
//  alu_data    in   DATA_W  ALU result
//  lsu_valid   in   1       load result offered
//  lsu_ready   out  1       buffer can accept; transfer when lsu_valid&&lsu_ready at posedge
//  lsu_reg     in   ADDR_W  load destination register
//  lsu_data    in   DATA_W  load data
//  issue_valid in   1       decode issued a load; mark issue_reg pending
//  issue_reg   in   ADDR_W  destination of issued load
//  chk_reg_a   in   ADDR_W  source register A to hazard-check
//  chk_reg_b   in   ADDR_W  source register B to hazard-check
//  stall       out  1       combinational: pending[chk_reg_a] | pending[chk_reg_b]
//  writeReg    out  ADDR_W  registered write index to register file
//  writeData   out  DATA_W  registered write data
//  regWrite    out  1       registered write enable
// BEHAVIOUR
//  - Reset (rst_n low, async): regWrite=0, writeReg=0, writeData=0, FIFO empty, pending=0,
//    lsu_ready=0 while held; lsu_ready=1 first cycle after release. Reset mid-operation
//    discards buffered LSU entries and pending bits; no write is issued for them.
//  - Register 0 is hardwired zero: any result targeting reg 0 is consumed but never written
//    (regWrite stays 0); issue_reg=0 never sets a pending bit; pending[0] is always 0.
//  - Per-edge arbitration, ALU has strict priority:
//      alu_valid && alu_reg!=0      -> output regs <= ALU result, regWrite<=1
//      else FIFO non-empty          -> pop head, output regs <= head, regWrite<=1
//      else                         -> regWrite<=0 (writeReg/writeData hold last value)
//    alu_valid with alu_reg=0 does not block a FIFO pop that cycle.
//    A popped head with reg 0 gives regWrite<=0.
//  - Latency: ALU accepted at edge k -> regWrite high in cycle after edge k (1 cycle).
//    LSU accepted at edge k -> earliest regWrite in cycle after edge k+1 (2 cycles); no bypass.
//  - FIFO: in-order, lsu_ready = (count < FIFO_DEPTH), registered, no pass-through when full.
//    Push and pop same edge: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  - LSU starvation while alu_valid continuously asserted is allowed; lsu_ready deasserts at full.
//  - Scoreboard pending[2**ADDR_W]: set at edge when issue_valid && issue_reg!=0;
//    cleared at the edge the matching LSU entry is popped. Set and clear of same reg on the
//    same edge: set wins (bit stays 1). ALU writes never modify pending bits.
//  - stall drops in the same cycle the load write appears on writeReg/regWrite.
//  - Ordering contract: decode must not issue an ALU op to a pending register (stall enforces).
// TESTING
//  1 Reset: drive traffic, pulse rst_n low mid-stream -> regWrite=0, writeReg=0, stall=0;
//    lsu_ready=1 one cycle after release; no stale LSU write ever appears.
//  2 ALU: alu_reg=5, alu_data=32'hDEADBEEF at edge k -> cycle k+1 regWrite=1, writeReg=5,
//    writeData=32'hDEADBEEF; next idle cycle regWrite=0.
//  3 Zero reg: alu_reg=0 data 32'h1 -> regWrite stays 0; issue_reg=0, chk_reg_a=0 -> stall=0.
//  4 Contention: alu_valid high 4 cycles, LSU offers regs 8,9,10 -> lsu_ready low after 2 pushes;
//    after ALU stops, writes 8,9,10 in order on 3 consecutive cycles, data intact.
//  5 Scoreboard: issue_reg=12, chk_reg_b=12 -> stall=1 until cycle regWrite=1 with writeReg=12,
//    stall=0 that cycle.
//  6 Simultaneous issue of reg 12 and pop of reg 12 -> pending[12] stays 1, stall stays 1.

Source files
------------

// File: rtl/reg_writeback_arbiter.sv
// reg_writeback_arbiter
//   Write-side front end of the register file. Merges single-cycle ALU results
//   and buffered load results into one registered write port, and keeps a
//   pending-load scoreboard so decode can stall on RAW hazards.
// Ports
//   clk, rst_n                      clock, async active-low reset
//   alu_valid/alu_reg/alu_data      ALU result (always accepted)
//   lsu_valid/lsu_ready/lsu_reg/lsu_data   load result handshake into buffer
//   issue_valid/issue_reg           load issued by decode; marks reg pending
//   chk_reg_a/chk_reg_b/stall       hazard check of two source registers
//   writeReg/writeData/regWrite     registered register-file write port
module reg_writeback_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [ADDR_W-1:0] lsu_reg,
    input  logic [DATA_W-1:0] lsu_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] chk_reg_a,
    input  logic [ADDR_W-1:0] chk_reg_b,
    output logic              stall,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              regWrite
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NREG  = 1 << ADDR_W;

    logic [ADDR_W-1:0] fifo_reg_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              lsu_ready_q;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;

    logic              alu_win, push, pop;
    logic [ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;

    assign head_reg  = fifo_reg_q[rd_ptr_q];
    assign head_data = fifo_data_q[rd_ptr_q];

    always_comb begin
        // An ALU result to reg 0 is dropped and does not take the port.
        alu_win = alu_valid && (alu_reg != '0);
        push    = lsu_valid && lsu_ready_q;
        pop     = !alu_win && (count_q != '0);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Clear on pop first, then set, so a same-edge issue of the same reg wins.
        pending_d = pending_q;
        if (pop && (head_reg != '0)) pending_d[head_reg] = 1'b0;
        if (issue_valid && (issue_reg != '0)) pending_d[issue_reg] = 1'b1;
        pending_d[0] = 1'b0;

        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        reg_write_d  = 1'b0;
        if (alu_win) begin
            write_reg_d  = alu_reg;
            write_data_d = alu_data;
            reg_write_d  = 1'b1;
        end else if (pop) begin
            write_reg_d  = head_reg;
            write_data_d = head_data;
            reg_write_d  = (head_reg != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lsu_ready_q  <= 1'b0;
            pending_q    <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q      <= count_d;
            // Registered ready from the next count: never accepts into a full buffer.
            lsu_ready_q  <= (count_d < CNT_W'(FIFO_DEPTH));
            pending_q    <= pending_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    // Buffer storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_reg_q[wr_ptr_q]  <= lsu_reg;
            fifo_data_q[wr_ptr_q] <= lsu_data;
        end
    end

    assign lsu_ready = lsu_ready_q;
    assign stall     = pending_q[chk_reg_a] | pending_q[chk_reg_b];
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;
    assign regWrite  = reg_write_q;

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
module tb_reg_writeback_arbiter;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_reg;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_reg;
    logic [4:0]  chk_reg_a;
    logic [4:0]  chk_reg_b;
    logic        stall;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic        regWrite;

    reg_writeback_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_reg(lsu_reg), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .chk_reg_a(chk_reg_a), .chk_reg_b(chk_reg_b), .stall(stall),
        .writeReg(writeReg), .writeData(writeData), .regWrite(regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    // Reference model: load buffer as a queue, scoreboard as a bit per register.
    ent_t        q[$];
    ent_t        offers[$];
    bit          pend[32];
    bit          exp_we;
    logic [4:0]  exp_reg;
    logic [31:0] exp_data;
    bit          m_ready;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (pend[i]) pend[i] = 1'b0;
        exp_we   = 1'b0;
        exp_reg  = '0;
        exp_data = '0;
        m_ready  = 1'b0;
    endtask

    task automatic model_edge();
        ent_t h;
        ent_t in_e;
        bit   pushed;
        if (!rst_n) begin
            model_reset();
        end else begin
            pushed = lsu_valid && m_ready;
            in_e.r = lsu_reg;
            in_e.d = lsu_data;
            if (alu_valid && alu_reg != 0) begin
                exp_we = 1'b1; exp_reg = alu_reg; exp_data = alu_data;
            end else if (q.size() > 0) begin
                h = q.pop_front();
                exp_we = (h.r != 0);
                if (h.r != 0) begin
                    exp_reg = h.r; exp_data = h.d; pend[h.r] = 1'b0;
                end
            end else begin
                exp_we = 1'b0;
            end
            if (pushed) begin
                q.push_back(in_e);
                void'(offers.pop_front());
            end
            if (issue_valid && issue_reg != 0) pend[issue_reg] = 1'b1;
            m_ready = (q.size() < DEPTH);
        end
    endtask

    task automatic check_outputs();
        chk("regWrite", regWrite, exp_we);
        chk("lsu_ready", lsu_ready, m_ready);
        if (exp_we || !rst_n) begin
            chk("writeReg", writeReg, exp_reg);
            chk("writeData", writeData, exp_data);
        end
    endtask

    // One cycle: drive inputs, check stall combinationally, clock, update model, check.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic iv, input logic [4:0] ir,
                        input logic [4:0] ca, input logic [4:0] cb);
        alu_valid   = av;
        alu_reg     = ar;
        alu_data    = ad;
        issue_valid = iv;
        issue_reg   = ir;
        chk_reg_a   = ca;
        chk_reg_b   = cb;
        lsu_valid   = (offers.size() != 0);
        if (offers.size() != 0) begin
            lsu_reg  = offers[0].r;
            lsu_data = offers[0].d;
        end
        #1;
        chk("stall", stall, pend[ca] | pend[cb]);
        @(posedge clk);
        #1;
        model_edge();
        check_outputs();
    endtask

    task automatic idle(input logic [4:0] ca, input logic [4:0] cb);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, ca, cb);
    endtask

    task automatic offer(input logic [4:0] r, input logic [31:0] d);
        ent_t e;
        e.r = r;
        e.d = d;
        offers.push_back(e);
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        lsu_valid = 0; lsu_reg = 0; lsu_data = 0;
        issue_valid = 0; issue_reg = 0; chk_reg_a = 0; chk_reg_b = 0;
        model_reset();

        // Reset values while held
        #2;
        chk("rst_regWrite", regWrite, 1'b0);
        chk("rst_writeReg", writeReg, 5'd0);
        chk("rst_writeData", writeData, 32'd0);
        chk("rst_lsu_ready", lsu_ready, 1'b0);
        chk("rst_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 0);
        chk("ready_after_release", lsu_ready, 1'b1);

        // ALU single write, then idle
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0, 5'd0);
        chk("alu_we", regWrite, 1'b1);
        chk("alu_reg", writeReg, 5'd5);
        chk("alu_data", writeData, 32'hDEADBEEF);
        idle(0, 0);
        chk("alu_idle_we", regWrite, 1'b0);

        // Register 0 is never written nor marked pending
        step(1'b1, 5'd0, 32'h1, 1'b1, 5'd0, 5'd0, 5'd0);
        chk("zero_we", regWrite, 1'b0);
        idle(0, 0);
        chk("zero_stall", stall, 1'b0);

        // Contention: ALU busy 4 cycles, loads to 8,9,10 queue behind it
        offer(5'd8, 32'h0000_0808);
        offer(5'd9, 32'h0000_0909);
        offer(5'd10, 32'h0000_0A0A);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 5'(i + 1), 32'h100 + 32'(i), 1'b0, 5'd0, 5'd0, 5'd0);
            if (i == 1) chk("cont_full_ready", lsu_ready, 1'b0);
        end
        idle(0, 0);
        chk("cont_w8", {regWrite, writeReg, writeData}, {1'b1, 5'd8, 32'h0000_0808});
        idle(0, 0);
        chk("cont_w9", {regWrite, writeReg, writeData}, {1'b1, 5'd9, 32'h0000_0909});
        idle(0, 0);
        chk("cont_w10", {regWrite, writeReg, writeData}, {1'b1, 5'd10, 32'h0000_0A0A});
        idle(0, 0);

        // Scoreboard: stall on reg 12 until the load write appears
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd12);
        idle(0, 12);
        chk("sb_stall_set", stall, 1'b1);
        offer(5'd12, 32'hC0DE_0012);
        idle(0, 12);
        chk("sb_stall_hold", stall, 1'b1);
        idle(0, 12);
        chk("sb_write12", {regWrite, writeReg}, {1'b1, 5'd12});
        chk("sb_stall_drop", stall, 1'b0);

        // Same-edge reissue of reg 12 and pop of reg 12: pending stays set
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd0, 5'd12);
        offer(5'd12, 32'hC0DE_1212);
        idle(12, 0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 5'd12, 5'd0);
        chk("sim_write12", {regWrite, writeReg}, {1'b1, 5'd12});
        chk("sim_stall", stall, 1'b1);
        offer(5'd12, 32'hC0DE_2222);
        for (int i = 0; i < 3; i++) idle(12, 0);
        chk("sim_stall_clear", stall, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (offers.size() < 3 && $urandom_range(0, 2) == 0)
                offer(5'($urandom_range(0, 15)), $urandom);
            step(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)), $urandom,
                 ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 15)),
                 5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end

        // Mid-stream reset with loads buffered and pending bits set
        for (int i = 0; i < 4; i++) begin
            offer(5'(20 + i), 32'hBAD0_0000 + 32'(i));
            step(1'b1, 5'd3, 32'h33, 1'b1, 5'(20 + i), 5'd0, 5'd0);
        end
        rst_n = 1'b0;
        lsu_valid = 1'b0;
        offers.delete();
        chk_reg_a = 5'd20;
        chk_reg_b = 5'd21;
        #1;
        model_edge();
        chk("mid_rst_we", regWrite, 1'b0);
        chk("mid_rst_reg", writeReg, 5'd0);
        chk("mid_rst_data", writeData, 32'd0);
        chk("mid_rst_ready", lsu_ready, 1'b0);
        chk("mid_rst_stall", stall, 1'b0);
        idle(20, 21);
        idle(22, 23);
        rst_n = 1'b1;
        idle(20, 21);
        chk("mid_rel_ready", lsu_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            idle(5'(20 + i), 5'd0);
            chk("no_stale_write", regWrite, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
